// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// No logic; no latency; no backpressure.
// Holds the FSM state encoding, RV32I size/sign codes and the default data width.
package lsu_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        FIN
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
// Purely combinational; zero latency.
// No flow control; the caller samples the outputs when it needs them.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] ram_word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merge_data
);

    logic [4:0]        sh_b;
    logic [4:0]        sh_h;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] mask_b;
    logic [DATA_W-1:0] mask_h;

    always_comb begin
        sh_b   = {off, 3'b000};
        sh_h   = {off[1], 4'b0000};
        lane_b = 8'(ram_word >> sh_b);
        lane_h = 16'(ram_word >> sh_h);
        mask_b = {{(DATA_W-8){1'b0}}, 8'hFF} << sh_b;
        mask_h = {{(DATA_W-16){1'b0}}, 16'hFFFF} << sh_h;

        load_data = ram_word;
        case (funct3)
            F3_B:    load_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
            F3_H:    load_data = {{(DATA_W-16){lane_h[15]}}, lane_h};
            F3_BU:   load_data = {{(DATA_W-8){1'b0}}, lane_b};
            F3_HU:   load_data = {{(DATA_W-16){1'b0}}, lane_h};
            default: ;
        endcase

        // Clear the target lane of the RAM word, then OR in the shifted store data.
        merge_data = wdata;
        case (funct3)
            F3_B:    merge_data = (ram_word & ~mask_b)
                                | ({{(DATA_W-8){1'b0}}, wdata[7:0]} << sh_b);
            F3_H:    merge_data = (ram_word & ~mask_h)
                                | ({{(DATA_W-16){1'b0}}, wdata[15:0]} << sh_h);
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core data port and a word-wide RAM (misalign trap: LSU_MISALIGN_TRAP_EN).
// Latency accept->DONE: LW/LB/LH 3, SW 2, SB/SH 4, no-op or trapped misalign 1 cycle.
// One access in flight; REQ is ignored while BUSY, the core holds REQ until DONE.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RAM_ADD = 10,
    parameter int ADDR_W  = 32
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               REQ,
    input  logic               WE,
    input  logic [2:0]         FUNCT3,
    input  logic [ADDR_W-1:0]  ADDR,
    input  logic [DATA_W-1:0]  WDATA,
    output logic               BUSY,
    output logic               DONE,
    output logic [DATA_W-1:0]  RDATA,
    output logic               MISALIGN,
    output logic [RAM_ADD-1:0] RAM_ADDRESS,
    output logic               RAM_OE,
    output logic               RAM_WR,
    output logic [DATA_W-1:0]  RAM_DATA_IN,
    input  logic [DATA_W-1:0]  RAM_DATA_OUT
);

    lsu_state_t        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] wdata_q;

    logic              f3_ok;
    logic              is_h;
    logic              is_w;
    logic              mis_in;
    logic [1:0]        off_in;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    // Upper address bits wrap the access onto the RAM.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDR[ADDR_W-1:RAM_ADD+2];

    always_comb begin
        is_h = (FUNCT3[1:0] == 2'b01);
        is_w = (FUNCT3[1:0] == 2'b10);
        case (FUNCT3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = !WE;
            default:          f3_ok = 1'b0;
        endcase
        off_in = ADDR[1:0];
        if (is_h) off_in[0] = 1'b0;
        if (is_w) off_in    = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_in = f3_ok && ((is_h && ADDR[0]) || (is_w && (ADDR[1:0] != 2'b00)));
`else
        mis_in = 1'b0;
`endif
    end

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3     (f3_q),
        .off        (off_q),
        .ram_word   (RAM_DATA_OUT),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            MISALIGN    <= 1'b0;
            RAM_OE      <= 1'b0;
            RAM_WR      <= 1'b0;
            RDATA       <= '0;
            RAM_ADDRESS <= '0;
            RAM_DATA_IN <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ) begin
                        we_q        <= WE;
                        f3_q        <= FUNCT3;
                        off_q       <= off_in;
                        wdata_q     <= WDATA;
                        RAM_ADDRESS <= ADDR[RAM_ADD+1:2];
                        BUSY        <= 1'b1;
                        if (!f3_ok || mis_in) begin
                            DONE     <= 1'b1;
                            MISALIGN <= mis_in;
                            state    <= FIN;
                        end else if (WE && FUNCT3 == F3_W) begin
                            RAM_WR      <= 1'b1;
                            RAM_DATA_IN <= WDATA;
                            state       <= WR;
                        end else begin
                            RAM_OE <= 1'b1;
                            state  <= RD;
                        end
                    end
                end
                RD: begin
                    RAM_OE <= 1'b0;
                    state  <= CAP;
                end
                CAP: begin
                    if (we_q) begin
                        RAM_DATA_IN <= merge_data;
                        RAM_WR      <= 1'b1;
                        state       <= WR;
                    end else begin
                        RDATA <= load_data;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end
                end
                WR: begin
                    RAM_WR <= 1'b0;
                    DONE   <= 1'b1;
                    state  <= FIN;
                end
                FIN: begin
                    DONE     <= 1'b0;
                    MISALIGN <= 1'b0;
                    BUSY     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
